// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants and helpers for the register-file write-back controller.
package regfile_wb_ctrl_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int NUM_REGS     = 32;
  localparam int XLEN_DEFAULT = 32;

  localparam logic [XLEN_DEFAULT-1:0] ZERO_WORD = '0;

  // One-hot mask selecting register idx; x0 never produces a bit.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic                 en,
                                                   input logic [REG_IDX_W-1:0] idx);
    reg_mask = '0;
    if (en && (idx != '0)) reg_mask[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_arbiter.sv
// wb_arbiter: one-hot grant over NREQ write-back requesters.
// WB_RR_EN selects round-robin with an internal pointer; otherwise fixed priority (index 0 wins).
module wb_arbiter #(
  parameter int NREQ = 3
) (
`ifdef WB_RR_EN
  input  logic            clk,
`endif
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

`ifdef WB_RR_EN
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             found;

  // Pass 0 scans indices at or above the pointer, pass 1 wraps to those below it.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    if (!rst) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req[i] && ((pass == 0) == (i >= int'(ptr)))) begin
            grant[i] = 1'b1;
            found    = 1'b1;
            ptr_nxt  = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates requesters onto the register-file write port and
// tracks pending writes for hazard detection. Define WB_RR_EN for round-robin arbitration.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [REG_IDX_W*NREQ-1:0] req_rd,
  input  logic [XLEN*NREQ-1:0]      req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      mark_valid,
  input  logic [REG_IDX_W-1:0]      mark_rd,
  input  logic [REG_IDX_W-1:0]      rs1,
  input  logic [REG_IDX_W-1:0]      rs2,
  input  logic [REG_IDX_W-1:0]      rd_q,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      rd_busy,
  output logic                      rf_wen,
  output logic [REG_IDX_W-1:0]      rf_rd,
  output logic [XLEN-1:0]           rf_wdata
);

  logic                 grant_any;
  logic [REG_IDX_W-1:0] sel_rd;
  logic [XLEN-1:0]      sel_data;

  logic [NUM_REGS-1:1]  pending;
  logic [NUM_REGS-1:1]  pending_nxt;
  logic [NUM_REGS-1:0]  set_mask;
  logic [NUM_REGS-1:0]  clr_mask;
  logic [NUM_REGS-1:0]  pending_full;

  wb_arbiter #(.NREQ(NREQ)) u_arbiter (
`ifdef WB_RR_EN
    .clk   (clk),
`endif
    .rst   (rst),
    .req   (req_valid),
    .grant (req_ready)
  );

  // Grant is one-hot, so OR-ing the selected slices picks the winner.
  always_comb begin
    grant_any = |req_ready;
    sel_rd    = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_rd   = req_rd[REG_IDX_W*i +: REG_IDX_W];
        sel_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  // A grant to x0 is consumed but never reaches the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      rf_wen <= grant_any && (sel_rd != '0);
      if (grant_any) begin
        rf_rd    <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

  // Clear on commit, then set on mark: a new producer supersedes the committing one.
  always_comb begin
    set_mask    = reg_mask(mark_valid, mark_rd);
    clr_mask    = reg_mask(rf_wen, rf_rd);
    pending_nxt = (pending & ~clr_mask[NUM_REGS-1:1]) | set_mask[NUM_REGS-1:1];
  end

  always_ff @(posedge clk) begin
    // NOTE: the pending bits are a handful of flops, not a RAM, so they take the reset.
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  assign pending_full = {pending, 1'b0};
  assign rs1_busy     = pending_full[rs1];
  assign rs2_busy     = pending_full[rs2];
  assign rd_busy      = pending_full[rd_q];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: rule-level reference model plus a write-port scoreboard.
module tb_regfile_wb_ctrl;
  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [5*NREQ-1:0]    req_rd;
  logic [XLEN*NREQ-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 mark_valid;
  logic [4:0]           mark_rd, rs1, rs2, rd_q;
  logic                 rs1_busy, rs2_busy, rd_busy;
  logic                 rf_wen;
  logic [4:0]           rf_rd;
  logic [XLEN-1:0]      rf_wdata;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .mark_valid(mark_valid), .mark_rd(mark_rd),
    .rs1(rs1), .rs2(rs2), .rd_q(rd_q),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    int              stamp;
  } wb_t;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  wb_t exp_q[$];

  // Reference model: pending set, write committing at the next edge, arbitration pointer.
  bit         pend[32];
  bit         infl_v  = 1'b0;
  logic [4:0] infl_rd = '0;
  int         rr_ptr  = 0;

  // Requester holders: each keeps its transaction until granted.
  bit              hv[NREQ];
  logic [4:0]      hrd[NREQ];
  logic [XLEN-1:0] hdat[NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] v);
`ifdef WB_RR_EN
    for (int k = 0; k < NREQ; k++)
      if (v[(rr_ptr + k) % NREQ]) return (rr_ptr + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++)
      if (v[k]) return k;
`endif
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = hv[i];
      req_rd[5*i +: 5]       = hrd[i];
      req_data[XLEN*i +: XLEN] = hdat[i];
    end
  endtask

  task automatic load(input int i, input logic [4:0] rd, input logic [XLEN-1:0] data);
    hv[i] = 1'b1; hrd[i] = rd; hdat[i] = data;
  endtask

  task automatic idle_reqs();
    for (int i = 0; i < NREQ; i++) hv[i] = 1'b0;
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, advance the model.
  task automatic step();
    int w;
    logic [NREQ-1:0] exp_ready;
    drive();
    @(negedge clk);
    w = rst ? -1 : model_pick(req_valid);
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    if (cyc > 0) begin
      check("rf_wen", rf_wen, infl_v);
      check("rs1_busy", rs1_busy, pend[rs1]);
      check("rs2_busy", rs2_busy, pend[rs2]);
      check("rd_busy", rd_busy, pend[rd_q]);
    end
    if (rst) begin
      foreach (pend[r]) pend[r] = 1'b0;
      infl_v = 1'b0;
      rr_ptr = 0;
    end else begin
      if (infl_v) pend[infl_rd] = 1'b0;
      if (mark_valid && mark_rd != 0) pend[mark_rd] = 1'b1;
      infl_v  = (w >= 0) && (hrd[w] != 0);
      infl_rd = (w >= 0) ? hrd[w] : 5'd0;
      if (infl_v) exp_q.push_back('{hrd[w], hdat[w], cyc});
      if (w >= 0) begin
        rr_ptr = (w + 1) % NREQ;
        hv[w]  = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write the DUT presents must match the oldest expected one, one cycle after its grant.
  always @(negedge clk) begin
    wb_t e;
    if (rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL wb_unexpected: write rd=%0d data=%0h with none expected (cycle %0d)",
                 rf_rd, rf_wdata, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wb_rd", rf_rd, e.rd);
        check("wb_data", rf_wdata, e.data);
        check("wb_latency", cyc, e.stamp + 1);
      end
    end
  end

  initial begin
    foreach (pend[r]) pend[r] = 1'b0;
    idle_reqs();
    for (int i = 0; i < NREQ; i++) begin hrd[i] = '0; hdat[i] = '0; end
    rst = 1'b1; mark_valid = 1'b0; mark_rd = '0; rs1 = '0; rs2 = '0; rd_q = '0;

    // Reset with all inputs active.
    for (int i = 0; i < NREQ; i++) load(i, 5'(i + 1), $urandom);
    mark_valid = 1'b1; mark_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd1; rd_q = 5'd2;
    repeat (2) step();
    check("rst_wen", rf_wen, 1'b0);
    check("rst_rd", rf_rd, 5'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    rst = 1'b0; idle_reqs(); mark_valid = 1'b0;
    step();

    // Single write of x5.
    mark_valid = 1'b1; mark_rd = 5'd5; rd_q = 5'd5;
    step();
    mark_valid = 1'b0;
    check("mark_to_busy", rd_busy, 1'b1);
    step();
    step();
    load(0, 5'd5, 32'hDEADBEEF);
    step();
    check("single_wen", rf_wen, 1'b1);
    check("single_rd", rf_rd, 5'd5);
    check("single_wdata", rf_wdata, 32'hDEADBEEF);
    check("busy_before_clear", rd_busy, 1'b1);
    step();
    check("busy_cleared", rd_busy, 1'b0);

    // Contention: all three valid with distinct rd, refilled when granted.
    for (int i = 0; i < NREQ; i++) load(i, 5'(10 + i), $urandom);
    for (int c = 0; c < 6; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (!hv[i]) load(i, 5'(13 + 3*c + i), $urandom);
    end
    hv[0] = 1'b0;
    repeat (4) step();
    idle_reqs();
    repeat (2) step();

    // Mark/clear collision on x7.
    mark_valid = 1'b1; mark_rd = 5'd7; rd_q = 5'd7;
    step();
    mark_valid = 1'b0;
    load(1, 5'd7, $urandom);
    step();
    check("collide_wen", rf_wen, 1'b1);
    mark_valid = 1'b1; mark_rd = 5'd7;
    step();
    mark_valid = 1'b0;
    check("collide_busy", rd_busy, 1'b1);
    step();

    // x0 write and x0 mark.
    load(2, 5'd0, 32'h1234);
    mark_valid = 1'b1; mark_rd = 5'd0; rs1 = 5'd0;
    step();
    mark_valid = 1'b0;
    check("x0_wen", rf_wen, 1'b0);
    check("x0_busy", rs1_busy, 1'b0);
    step();

    // Reset mid-operation with a request on the same cycle.
    mark_valid = 1'b1; mark_rd = 5'd3; step();
    mark_rd = 5'd4; step();
    mark_valid = 1'b0; rs1 = 5'd3; rs2 = 5'd4;
    load(0, 5'd9, $urandom);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_wen", rf_wen, 1'b0);
    check("midrst_busy", rs1_busy, 1'b0);
    step();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      mark_valid = $urandom_range(0, 1);
      mark_rd    = 5'($urandom_range(0, 31));
      rs1        = 5'($urandom_range(0, 31));
      rs2        = 5'($urandom_range(0, 31));
      rd_q       = 5'($urandom_range(0, 31));
      for (int i = 0; i < NREQ; i++)
        if (!hv[i] && $urandom_range(0, 1) == 1) load(i, 5'($urandom_range(0, 31)), $urandom);
      step();
    end

    // Drain and confirm every expected write appeared.
    rst = 1'b0; mark_valid = 1'b0; idle_reqs();
    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the 32×32 register file. It arbitrates NREQ write-back requesters (ALU, load unit, CSR unit) onto the register file's single write port. It also holds a pending-write scoreboard so the issue stage can detect RAW/WAW hazards. The block sits between the execute/memory stages and the register file and drives the file's write enable, destination index and write data.

## Interface
- NREQ, 3: number of write-back requesters; index 0 is highest priority in fixed mode.
- XLEN, 32: data width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i holds a result.
- req_rd  in  5·NREQ  destination index, slice i = [5i+4:5i].
- req_data  in  XLEN·NREQ  result data, slice i.
- req_ready  out  NREQ  one-hot grant; a transfer completes when valid & ready.
- mark_valid  in  1  issue stage dispatches an instruction writing mark_rd.
- mark_rd  in  5  destination being marked pending.
- rs1, rs2, rd_q  in  5 each  issue-stage hazard queries.
- rs1_busy, rs2_busy, rd_busy  out  1 each  queried register has a pending write.
- rf_wen  out  1  register-file write enable.
- rf_rd  out  5  register-file write index.
- rf_wdata  out  XLEN  register-file write data.

## Operation
- Arbitration, combinational in cycle N:
  - At most one req_ready bit is high; it is high only for a requester with req_valid=1.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
  - A requester holds valid, rd and data stable until granted.
- Write port, registered:
  - A grant in cycle N drives rf_wen=1, rf_rd and rf_wdata in cycle N+1.
  - With no grant in N, rf_wen=0 in N+1; rf_rd and rf_wdata hold their last values.
- x0 handling:
  - A granted request with rd=0 is consumed (ready=1) but produces rf_wen=0.
  - mark_rd=0 is ignored, and x0 always reads not-busy.
- Scoreboard: 31 pending bits, for x1..x31.
  - Set: mark_valid with mark_rd≠0 sets bit mark_rd at the end of cycle N.
  - Clear: rf_wen=1 clears bit rf_rd at the end of that cycle, i.e. at the edge that commits the write.
  - Same register set and cleared in the same cycle: set wins, because a new producer supersedes the old one.
  - Marking an already-pending register leaves it pending. The issue stage stalls on rd_busy to prevent WAW; the block does not count producers.
- Busy outputs are combinational reads of the scoreboard, with no bypass from same-cycle marks.
- Reset: all pending bits 0, rf_wen=0, rf_rd=0, rf_wdata=0, req_ready=0, arbitration pointer=0.
  - A reset mid-stream drops any grant in flight.
  - The cycle after rst deasserts behaves as the first idle cycle.

## Timing
- Grant-to-write latency: 1 cycle, with the register-file write at the end of N+1.
- Grant-to-busy-clear: busy reads 0 from cycle N+2. This is the first cycle in which the register file returns the new value.
- Mark-to-busy: mark in cycle N gives busy=1 from cycle N+1.
- Throughput: one write per cycle; the write port never back-pressures.

## Configuration
- WB_RR_EN defined: round-robin arbitration.
  - A pointer p names the highest-priority requester.
  - After a grant to i, p becomes (i+1) mod NREQ. With no grant, p is unchanged.
- WB_RR_EN undefined: fixed priority; the lowest-index valid requester wins.
  - The pointer register is not present.

## Structure
- The shared constants include file holds:
  - the zero word;
  - register-index width 5;
  - register count 32;
  - XLEN default.
- One sub-module, wb_arbiter: NREQ request vector in, one-hot grant out, pointer inside it under WB_RR_EN.
- Scoreboard and write-port registers live in regfile_wb_ctrl.

## Test plan
- Reset: hold rst 2 cycles with all inputs active. Expect rf_wen=0, all busy=0, req_ready=0 while rst is high and in the first cycle after.
- Single write: mark x5 in cycle 0, giving rd_busy(x5)=1 in cycle 1. req0 writes x5=0xDEADBEEF in cycle 3. Expect rf_wen=1, rf_rd=5, rf_wdata=0xDEADBEEF in cycle 4, and busy(x5)=0 from cycle 5.
- Contention, all three valid for 6 cycles, distinct rd:
  - Fixed mode: grants 0,0,… until req0 drops.
  - WB_RR_EN: grants 0,1,2,0,1,2.
- Mark/clear collision: x7 pending and being written (rf_wen=1, rf_rd=7) while mark_rd=7 in the same cycle. Expect busy(x7) to stay 1.
- x0: a req with rd=0 and data 0x1234 is granted, and rf_wen stays 0. mark_rd=0 leaves rs1_busy for rs1=0 at 0.
- Reset mid-operation: grant in cycle N with rst=1 in N. Expect rf_wen=0 in N+1 and the scoreboard cleared.
